// File: rtl/countdown_timer_if.sv
// Button-pulse inputs and display/status outputs of the countdown timer.
interface countdown_timer_if;
  logic       start_stop_pressed_i;
  logic       set_pressed_i;
  logic       change_pressed_i;
  logic [6:0] hex3_o;
  logic [6:0] hex2_o;
  logic [6:0] hex1_o;
  logic [6:0] hex0_o;
  logic       running_o;
  logic       done_o;

  modport master (
    output start_stop_pressed_i, set_pressed_i, change_pressed_i,
    input  hex3_o, hex2_o, hex1_o, hex0_o, running_o, done_o
  );

  modport slave (
    input  start_stop_pressed_i, set_pressed_i, change_pressed_i,
    output hex3_o, hex2_o, hex1_o, hex0_o, running_o, done_o
  );
endinterface

// File: rtl/countdown_timer.sv
// Presettable SS.hh BCD countdown timer with pause/resume and expiry flag.
// Optional COUNTDOWN_BLINK_EN blanks the display periodically while expired.
module countdown_timer #(
  parameter int unsigned PULSE_MAX   = 999999,
  parameter int unsigned BLINK_TICKS = 50
) (
  input  logic             clk100_i,
  input  logic             rstn_i,
  countdown_timer_if.slave bus
);

  localparam int unsigned CNT_W = 20;
  localparam int unsigned VAL_W = 16;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_EDIT_0  = 4'd1;
  localparam logic [3:0] S_EDIT_1  = 4'd2;
  localparam logic [3:0] S_EDIT_2  = 4'd3;
  localparam logic [3:0] S_EDIT_3  = 4'd4;
  localparam logic [3:0] S_RUNNING = 4'd5;
  localparam logic [3:0] S_PAUSED  = 4'd6;
  localparam logic [3:0] S_EXPIRED = 4'd7;

  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low gfedcba segment pattern for one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [VAL_W-1:0] bcd_dec(input logic [VAL_W-1:0] v);
    logic [VAL_W-1:0] r;
    logic             borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Edit-mode digit increment: 9 wraps to 0 without touching neighbours.
  function automatic logic [VAL_W-1:0] inc_digit(input logic [VAL_W-1:0] v,
                                                 input logic [1:0] idx);
    logic [VAL_W-1:0] r;
    r = v;
    if (v[{idx, 2'b00} +: 4] == 4'd9) r[{idx, 2'b00} +: 4] = 4'd0;
    else                              r[{idx, 2'b00} +: 4] = v[{idx, 2'b00} +: 4] + 4'd1;
    return r;
  endfunction

  logic [3:0]       state_q,  state_d;
  logic [VAL_W-1:0] digits_q, digits_d;
  logic [VAL_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] cnt_adv;
  logic [VAL_W-1:0] dec_val;
  logic             tick;
  logic             running_q, done_q;
  logic [6:0]       hex3_q, hex2_q, hex1_q, hex0_q;
  logic [6:0]       hex3_d, hex2_d, hex1_d, hex0_d;

  logic ss, set, chg;
  assign ss  = bus.start_stop_pressed_i;
  assign set = bus.set_pressed_i;
  assign chg = bus.change_pressed_i;

  if (BLINK_TICKS == 0) begin : g_no_blink_period
  end

`ifdef COUNTDOWN_BLINK_EN
  localparam int unsigned TCNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  logic [TCNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              blink_q,    blink_d;

  assign tick = (cnt_q == CNT_W'(PULSE_MAX)) &&
                ((state_q == S_RUNNING) || (state_q == S_EXPIRED));
`else
  assign tick = (cnt_q == CNT_W'(PULSE_MAX)) && (state_q == S_RUNNING);
`endif

  assign cnt_adv = tick ? '0 : cnt_q + CNT_W'(1);
  assign dec_val = bcd_dec(digits_q);

  // Next-state, digit and counter logic; start_stop > set > change.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    preset_d = preset_q;
    cnt_d    = cnt_q;
`ifdef COUNTDOWN_BLINK_EN
    tick_cnt_d = tick_cnt_q;
    blink_d    = blink_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ss && (digits_q != '0)) begin
          state_d  = S_RUNNING;
          preset_d = digits_q;
          cnt_d    = '0;
        end else if (set) begin
          state_d = S_EDIT_0;
        end
      end
      S_EDIT_0, S_EDIT_1, S_EDIT_2, S_EDIT_3: begin
        if (set) begin
          state_d = (state_q == S_EDIT_3) ? S_IDLE : state_q + 4'd1;
        end else if (chg) begin
          digits_d = inc_digit(digits_q, 2'(state_q - S_EDIT_0));
        end
      end
      S_RUNNING: begin
        cnt_d = cnt_adv;
        if (tick) begin
          digits_d = dec_val;
          if (dec_val == '0) state_d = S_EXPIRED;
          else if (ss)       state_d = S_PAUSED;
        end else if (ss) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (ss) begin
          state_d = S_RUNNING;
        end else if (set) begin
          state_d  = S_IDLE;
          digits_d = preset_q;
        end
      end
      S_EXPIRED: begin
        digits_d = '0;
        if (ss || set) begin
          state_d  = S_IDLE;
          digits_d = preset_q;
        end
`ifdef COUNTDOWN_BLINK_EN
        cnt_d = cnt_adv;
        if (tick) begin
          if (tick_cnt_q == TCNT_W'(BLINK_TICKS - 1)) begin
            tick_cnt_d = '0;
            blink_d    = ~blink_q;
          end else begin
            tick_cnt_d = tick_cnt_q + TCNT_W'(1);
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
`ifdef COUNTDOWN_BLINK_EN
    if (state_q == S_EXPIRED && state_d != S_EXPIRED) begin
      cnt_d      = '0;
      tick_cnt_d = '0;
      blink_d    = 1'b0;
    end
`endif
  end

  // Display is registered from next-state digits so it tracks digits_q exactly.
  always_comb begin
    hex3_d = seg7(digits_d[15:12]);
    hex2_d = seg7(digits_d[11:8]);
    hex1_d = seg7(digits_d[7:4]);
    hex0_d = seg7(digits_d[3:0]);
`ifdef COUNTDOWN_BLINK_EN
    if (blink_d) begin
      hex3_d = SEG_BLANK;
      hex2_d = SEG_BLANK;
      hex1_d = SEG_BLANK;
      hex0_d = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      digits_q  <= '0;
      preset_q  <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      hex3_q    <= SEG_ZERO;
      hex2_q    <= SEG_ZERO;
      hex1_q    <= SEG_ZERO;
      hex0_q    <= SEG_ZERO;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      preset_q  <= preset_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == S_RUNNING);
      done_q    <= (state_d == S_EXPIRED);
      hex3_q    <= hex3_d;
      hex2_q    <= hex2_d;
      hex1_q    <= hex1_d;
      hex0_q    <= hex0_d;
    end
  end

`ifdef COUNTDOWN_BLINK_EN
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tick_cnt_q <= '0;
      blink_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      blink_q    <= blink_d;
    end
  end
`endif

  assign bus.hex3_o    = hex3_q;
  assign bus.hex2_o    = hex2_q;
  assign bus.hex1_o    = hex1_q;
  assign bus.hex0_o    = hex0_q;
  assign bus.running_o = running_q;
  assign bus.done_o    = done_q;

endmodule
